// File: rtl/sort_mem_arbiter_if.sv
// Bundle between the two requesters, the data RAM and the sort_mem_arbiter.
// The arbiter connects through the slave modport; requesters and the RAM use the master side.
interface sort_mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              i_s_rd_en;
    logic              i_s_wr_en;
    logic [ADDR_W-1:0] i_s_addr;
    logic [DATA_W-1:0] i_s_wdata;
    logic [DATA_W-1:0] o_s_rdata;
    logic              o_s_valid_rd;
    logic              o_s_valid_wr;

    logic              i_h_rd_en;
    logic              i_h_wr_en;
    logic [ADDR_W-1:0] i_h_addr;
    logic [DATA_W-1:0] i_h_wdata;
    logic [DATA_W-1:0] o_h_rdata;
    logic              o_h_valid_rd;
    logic              o_h_valid_wr;

    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    logic [1:0]        o_grant;
    logic              o_busy;
    logic              o_proto_err;
    logic [1:0]        o_dbg_state;

    // Handshake: a requester holds rd_en or wr_en (with stable addr/wdata until granted)
    // until its one-cycle valid_rd/valid_wr pulse; that pulse is the only acknowledge.
    modport slave (
        input  i_s_rd_en, i_s_wr_en, i_s_addr, i_s_wdata,
        output o_s_rdata, o_s_valid_rd, o_s_valid_wr,
        input  i_h_rd_en, i_h_wr_en, i_h_addr, i_h_wdata,
        output o_h_rdata, o_h_valid_rd, o_h_valid_wr,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata,
        output o_grant, o_busy, o_proto_err, o_dbg_state
    );

    modport master (
        output i_s_rd_en, i_s_wr_en, i_s_addr, i_s_wdata,
        input  o_s_rdata, o_s_valid_rd, o_s_valid_wr,
        output i_h_rd_en, i_h_wr_en, i_h_addr, i_h_wdata,
        input  o_h_rdata, o_h_valid_rd, o_h_valid_wr,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata,
        input  o_grant, o_busy, o_proto_err, o_dbg_state
    );
endinterface

// File: rtl/sort_mem_arbiter.sv
// Round-robin arbiter/sequencer giving the sort control unit (S) and the host port (H)
// shared access to a single-port data RAM with RD_LAT-cycle read latency.
module sort_mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    sort_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // 0 = S, 1 = H
    logic              last_q, last_d;     // last served requester, same encoding
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] s_rdata_q, s_rdata_d;
    logic [DATA_W-1:0] h_rdata_q, h_rdata_d;
    logic              err_q, err_d;

    logic s_req, h_req, pick_h;

    assign s_req  = bus.i_s_rd_en | bus.i_s_wr_en;
    assign h_req  = bus.i_h_rd_en | bus.i_h_wr_en;
    // H wins when it is alone, or when both ask and S was served last.
    assign pick_h = h_req & (~s_req | ~last_q);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            s_rdata_q <= '0;
            h_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            s_rdata_q <= s_rdata_d;
            h_rdata_q <= h_rdata_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        s_rdata_d = s_rdata_q;
        h_rdata_d = h_rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (s_req | h_req) begin
                    owner_d = pick_h;
                    last_d  = pick_h;
                    state_d = ACCESS;
                    // rd_en together with wr_en is treated as a write and flagged.
                    if (pick_h) begin
                        we_d    = bus.i_h_wr_en;
                        addr_d  = bus.i_h_addr;
                        wdata_d = bus.i_h_wdata;
                        err_d   = err_q | (bus.i_h_rd_en & bus.i_h_wr_en);
                    end else begin
                        we_d    = bus.i_s_wr_en;
                        addr_d  = bus.i_s_addr;
                        wdata_d = bus.i_s_wdata;
                        err_d   = err_q | (bus.i_s_rd_en & bus.i_s_wr_en);
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = RD_WAIT;
                    cnt_d   = 2'(RD_LAT - 1);
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (owner_q) h_rdata_d = bus.i_mem_rdata;
                    else         s_rdata_d = bus.i_mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic in_access, in_resp, busy;

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    assign bus.o_mem_en     = in_access;
    assign bus.o_mem_we     = in_access & we_q;
    assign bus.o_mem_addr   = addr_q;
    assign bus.o_mem_wdata  = wdata_q;

    assign bus.o_s_rdata    = s_rdata_q;
    assign bus.o_h_rdata    = h_rdata_q;
    assign bus.o_s_valid_rd = in_resp & ~owner_q & ~we_q;
    assign bus.o_s_valid_wr = in_resp & ~owner_q &  we_q;
    assign bus.o_h_valid_rd = in_resp &  owner_q & ~we_q;
    assign bus.o_h_valid_wr = in_resp &  owner_q &  we_q;

    assign bus.o_grant      = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.o_busy       = busy;
    assign bus.o_proto_err  = err_q;
    assign bus.o_dbg_state  = state_q;

endmodule
